// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: generates the PS/2 clock, frames one byte as
// start/8 data LSB-first/odd parity/stop, and retries the whole frame after host inhibit.
module ps2_device_tx #(
    parameter int unsigned HALF_PERIOD = 2000,
    parameter int unsigned IDLE_CYC    = 2500,
    parameter int unsigned SETTLE_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        ps2_clk_io,
    inout  wire        ps2_data_io,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_done_o,
    output logic       tx_abort_o,
    output logic       busy_o,
    output logic       host_rts_o
);

    localparam int unsigned HW = $clog2(HALF_PERIOD + 1);
    localparam int unsigned IW = $clog2(IDLE_CYC + 1);

    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);
    localparam logic [HW-1:0] SETTLE_LIM = HW'(SETTLE_CYC);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYC - 1);
    localparam logic [3:0]    LAST_BIT   = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_HIGH,
        S_LOW,
        S_STOP_HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [HW-1:0] phase_cnt_q, phase_cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    data_q, data_d;
    logic          parity_q, parity_d;
    logic [1:0]    clk_sync_q, data_sync_q;

    logic        clk_s, data_s;
    logic        clk_low, data_low;
    logic        done, abort;
    logic [15:0] frame;
    logic        cur_bit;

    // Synchronisers reset to the pulled-up idle level so reset never looks like an RTS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_io};
            data_sync_q <= {data_sync_q[0], ps2_data_io};
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    assign frame   = {5'b11111, 1'b1, parity_q, data_q, 1'b0};
    assign cur_bit = frame[bit_idx_q];

    assign host_rts_o = (state_q == S_IDLE) && clk_s && !data_s;
    assign tx_ready_o = (state_q == S_IDLE) && !host_rts_o;
    assign busy_o     = (state_q != S_IDLE);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        phase_cnt_d = phase_cnt_q;
        bit_idx_d   = bit_idx_q;
        data_d      = data_q;
        parity_d    = parity_q;
        clk_low     = 1'b0;
        data_low    = 1'b0;
        done        = 1'b0;
        abort       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_valid_i && tx_ready_o) begin
                    data_d     = tx_data_i;
                    parity_d   = ~^tx_data_i;
                    idle_cnt_d = '0;
                    state_d    = S_WAIT_BUS;
                end
            end

            S_WAIT_BUS: begin
                if (clk_s && data_s) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        idle_cnt_d  = '0;
                        phase_cnt_d = '0;
                        bit_idx_d   = '0;
                        state_d     = S_HIGH;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end

            S_HIGH: begin
                data_low = !cur_bit;
                // Inhibit releases data in the same cycle; the held byte is resent from the start bit.
                if ((phase_cnt_q >= SETTLE_LIM) && !clk_s) begin
                    data_low    = 1'b0;
                    abort       = 1'b1;
                    idle_cnt_d  = '0;
                    phase_cnt_d = '0;
                    bit_idx_d   = '0;
                    state_d     = S_WAIT_BUS;
                end else if (phase_cnt_q == HALF_LAST) begin
                    phase_cnt_d = '0;
                    state_d     = S_LOW;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end

            S_LOW: begin
                clk_low  = 1'b1;
                data_low = !cur_bit;
                if (phase_cnt_q == HALF_LAST) begin
                    phase_cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = S_STOP_HOLD;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        state_d   = S_HIGH;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end

            S_STOP_HOLD: begin
                if (phase_cnt_q == HALF_LAST) begin
                    phase_cnt_d = '0;
                    bit_idx_d   = '0;
                    done        = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idle_cnt_q  <= '0;
            phase_cnt_q <= '0;
            bit_idx_q   <= '0;
            data_q      <= '0;
            parity_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            bit_idx_q   <= bit_idx_d;
            data_q      <= data_d;
            parity_q    <= parity_d;
        end
    end

    assign tx_done_o  = done;
    assign tx_abort_o = abort;

    // Drive enables decode straight from state, so reset or abort frees the bus without waiting a clock.
    assign ps2_clk_io  = clk_low  ? 1'b0 : 1'bz;
    assign ps2_data_io = data_low ? 1'b0 : 1'bz;

endmodule
